// File: rtl/bidi_count_monitor.sv
// Receive-side checker for a bidirectional counter stream: infers direction, locks onto the
// sequence, and flags step errors, direction changes and wraps. Optional irq under BDMON_IRQ_EN.
module bidi_count_monitor #(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 16,
    parameter int MISS_LIMIT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             clr,
    output logic             locked,
    output logic             dir,
    output logic             step_ok,
    output logic             err_pulse,
    output logic             dir_chg,
    output logic             wrap_pulse,
    output logic             lost,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count,
    output logic             irq
);

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

    localparam logic [3:0] MISS_LAST = 4'(MISS_LIMIT - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] prev_reg;
    logic             dir_reg, dir_next;
    logic [3:0]       miss_reg, miss_next;
    logic             step_ok_reg, step_ok_next;
    logic             err_reg, err_next;
    logic             dir_chg_reg, dir_chg_next;
    logic             wrap_reg, wrap_next;
    logic             lost_reg, lost_next;
    logic [CNT_W-1:0] err_count_reg, wrap_count_reg;

    logic [WIDTH-1:0] up_val, down_val;
    logic             is_up, is_down, is_wrap;

    assign up_val   = prev_reg + 1'b1;
    assign down_val = prev_reg - 1'b1;
    assign is_up    = (cnt_in == up_val);
    assign is_down  = (cnt_in == down_val);
    assign is_wrap  = (is_up && (prev_reg == '1)) || (is_down && (prev_reg == '0));

    always_comb begin
        state_next   = state_reg;
        dir_next     = dir_reg;
        miss_next    = miss_reg;
        step_ok_next = 1'b0;
        err_next     = 1'b0;
        dir_chg_next = 1'b0;
        wrap_next    = 1'b0;
        lost_next    = 1'b0;
        if (sample_en) begin
            case (state_reg)
                IDLE: state_next = ACQ;
                ACQ: begin
                    if (is_up || is_down) begin
                        dir_next     = is_up;
                        state_next   = LOCKED;
                        step_ok_next = 1'b1;
                        wrap_next    = is_wrap;
                    end
                end
                LOCKED: begin
                    if (dir_reg ? is_up : is_down) begin
                        step_ok_next = 1'b1;
                        wrap_next    = is_wrap;
                        miss_next    = '0;
                    end else if (dir_reg ? is_down : is_up) begin
                        dir_next     = ~dir_reg;
                        dir_chg_next = 1'b1;
                        step_ok_next = 1'b1;
                        wrap_next    = is_wrap;
                        miss_next    = '0;
                    end else begin
                        err_next = 1'b1;
                        // Last tolerated miss drops lock and restarts acquisition
                        if (miss_reg == MISS_LAST) begin
                            lost_next  = 1'b1;
                            state_next = ACQ;
                            miss_next  = '0;
                        end else begin
                            miss_next = miss_reg + 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            prev_reg       <= '0;
            dir_reg        <= 1'b1;
            miss_reg       <= '0;
            step_ok_reg    <= 1'b0;
            err_reg        <= 1'b0;
            dir_chg_reg    <= 1'b0;
            wrap_reg       <= 1'b0;
            lost_reg       <= 1'b0;
            err_count_reg  <= '0;
            wrap_count_reg <= '0;
        end else begin
            state_reg   <= state_next;
            dir_reg     <= dir_next;
            miss_reg    <= miss_next;
            step_ok_reg <= step_ok_next;
            err_reg     <= err_next;
            dir_chg_reg <= dir_chg_next;
            wrap_reg    <= wrap_next;
            lost_reg    <= lost_next;
            if (sample_en) begin
                prev_reg <= cnt_in;
            end
            // Clear wins over a same-cycle increment; tallies stick at all-ones
            if (clr) begin
                err_count_reg  <= '0;
                wrap_count_reg <= '0;
            end else begin
                if (err_next && (err_count_reg != '1)) begin
                    err_count_reg <= err_count_reg + 1'b1;
                end
                if (wrap_next && (wrap_count_reg != '1)) begin
                    wrap_count_reg <= wrap_count_reg + 1'b1;
                end
            end
        end
    end

    assign locked     = (state_reg == LOCKED);
    assign dir        = dir_reg;
    assign step_ok    = step_ok_reg;
    assign err_pulse  = err_reg;
    assign dir_chg    = dir_chg_reg;
    assign wrap_pulse = wrap_reg;
    assign lost       = lost_reg;
    assign err_count  = err_count_reg;
    assign wrap_count = wrap_count_reg;

`ifdef BDMON_IRQ_EN
    logic irq_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_reg <= 1'b0;
        end else if (clr) begin
            irq_reg <= 1'b0;
        end else if (err_next || lost_next) begin
            irq_reg <= 1'b1;
        end
    end

    assign irq = irq_reg;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_bidi_count_monitor.sv
// Directed bench for bidi_count_monitor: a sample-stream model checked every cycle, plus
// literal expectations; a second instance with CNT_W=2 exercises tally saturation.
module tb_bidi_count_monitor;

    localparam int MISS_LIMIT = 3;

    logic       clk;
    logic       reset;
    logic       sample_en;
    logic [7:0] cnt_in;
    logic       clr;

    logic        locked, dir, step_ok, err_pulse, dir_chg, wrap_pulse, lost, irq;
    logic [15:0] err_count, wrap_count;
    logic        s_locked, s_dir, s_step_ok, s_err_pulse, s_dir_chg, s_wrap_pulse, s_lost, s_irq;
    logic [1:0]  s_err_count, s_wrap_count;

    bidi_count_monitor #(.WIDTH(8), .CNT_W(16), .MISS_LIMIT(MISS_LIMIT)) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .cnt_in(cnt_in), .clr(clr),
        .locked(locked), .dir(dir), .step_ok(step_ok), .err_pulse(err_pulse),
        .dir_chg(dir_chg), .wrap_pulse(wrap_pulse), .lost(lost),
        .err_count(err_count), .wrap_count(wrap_count), .irq(irq)
    );

    bidi_count_monitor #(.WIDTH(8), .CNT_W(2), .MISS_LIMIT(MISS_LIMIT)) dut_s (
        .clk(clk), .reset(reset), .sample_en(sample_en), .cnt_in(cnt_in), .clr(clr),
        .locked(s_locked), .dir(s_dir), .step_ok(s_step_ok), .err_pulse(s_err_pulse),
        .dir_chg(s_dir_chg), .wrap_pulse(s_wrap_pulse), .lost(s_lost),
        .err_count(s_err_count), .wrap_count(s_wrap_count), .irq(s_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: what the monitor knows about the stream so far
    bit m_have, m_locked, m_dir, m_irq;
    int m_prev, m_miss, m_errs, m_wraps;
    bit m_ok, m_err, m_chg, m_wrap, m_lost;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_update();
        int d;
        bit valid, wrapped;
        if (reset) begin
            m_have = 0; m_locked = 0; m_dir = 1; m_irq = 0;
            m_prev = 0; m_miss = 0; m_errs = 0; m_wraps = 0;
            m_ok = 0; m_err = 0; m_chg = 0; m_wrap = 0; m_lost = 0;
        end else begin
            m_ok = 0; m_err = 0; m_chg = 0; m_wrap = 0; m_lost = 0;
            if (sample_en) begin
                d       = (int'(cnt_in) - m_prev + 256) % 256;
                valid   = (d == 1) || (d == 255);
                wrapped = (m_prev == 255 && cnt_in == 0) || (m_prev == 0 && cnt_in == 255);
                if (!m_have) begin
                    m_have = 1;
                end else if (!m_locked) begin
                    if (valid) begin
                        m_locked = 1;
                        m_dir    = (d == 1);
                        m_ok     = 1;
                        m_wrap   = wrapped;
                    end
                end else if (valid) begin
                    m_ok   = 1;
                    m_miss = 0;
                    m_wrap = wrapped;
                    if ((d == 1) != m_dir) begin
                        m_chg = 1;
                        m_dir = (d == 1);
                    end
                end else begin
                    m_err = 1;
                    m_miss++;
                    if (m_miss == MISS_LIMIT) begin
                        m_lost   = 1;
                        m_locked = 0;
                        m_miss   = 0;
                    end
                end
                m_prev = int'(cnt_in);
            end
            if (clr) begin
                m_errs = 0; m_wraps = 0; m_irq = 0;
            end else begin
                m_errs  += int'(m_err);
                m_wraps += int'(m_wrap);
`ifdef BDMON_IRQ_EN
                if (m_err || m_lost) m_irq = 1;
`endif
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("locked", int'(locked), int'(m_locked));
            chk("dir", int'(dir), int'(m_dir));
            chk("step_ok", int'(step_ok), int'(m_ok));
            chk("err_pulse", int'(err_pulse), int'(m_err));
            chk("dir_chg", int'(dir_chg), int'(m_chg));
            chk("wrap_pulse", int'(wrap_pulse), int'(m_wrap));
            chk("lost", int'(lost), int'(m_lost));
            chk("err_count", int'(err_count), sat(m_errs, 65535));
            chk("wrap_count", int'(wrap_count), sat(m_wraps, 65535));
            chk("irq", int'(irq), int'(m_irq));
            chk("s_locked", int'(s_locked), int'(m_locked));
            chk("s_err_count", int'(s_err_count), sat(m_errs, 3));
            chk("s_wrap_count", int'(s_wrap_count), sat(m_wraps, 3));
        end
    end

    task automatic step(input bit en, input int v, input bit c);
        sample_en = en;
        cnt_in    = 8'(v);
        clr       = c;
        @(posedge clk);
        model_update();
        #1;
        $display("step en=%0d cnt=%0d clr=%0d -> locked=%0d dir=%0d ok=%0d err=%0d chg=%0d wrap=%0d lost=%0d errc=%0d wrapc=%0d",
                 en, v, c, locked, dir, step_ok, err_pulse, dir_chg, wrap_pulse, lost, err_count, wrap_count);
    endtask

    task automatic do_reset();
        reset = 1'b1; sample_en = 1'b0; clr = 1'b0; cnt_in = 8'd0;
        @(posedge clk);
        model_update();
        #1;
        reset = 1'b0;
        $display("reset");
    endtask

    initial begin
        reset = 1'b1; sample_en = 1'b0; clr = 1'b0; cnt_in = 8'd0;
        do_reset();
        cmp_en = 1'b1;
        chk("rst_locked", int'(locked), 0);
        chk("rst_dir", int'(dir), 1);
        chk("rst_err_count", int'(err_count), 0);

        // Lock-up on a rising sequence
        step(1, 10, 0);
        chk("idle_no_lock", int'(locked), 0);
        step(1, 11, 0);
        chk("lock_after_11", int'(locked), 1);
        chk("ok_on_11", int'(step_ok), 1);
        step(1, 12, 0);
        step(1, 13, 0);
        chk("up_dir", int'(dir), 1);
        chk("up_err_count", int'(err_count), 0);

        // Up wrap, then reverse through a down wrap
        do_reset();
        step(1, 253, 0);
        step(1, 254, 0);
        step(1, 255, 0);
        step(1, 0, 0);
        chk("wrap_up_pulse", int'(wrap_pulse), 1);
        step(1, 1, 0);
        chk("wrap_count_1", int'(wrap_count), 1);
        step(1, 0, 0);
        chk("rev_dir_chg", int'(dir_chg), 1);
        step(1, 255, 0);
        chk("wrap_down_pulse", int'(wrap_pulse), 1);
        step(1, 254, 0);
        chk("wrap_count_2", int'(wrap_count), 2);
        chk("down_dir", int'(dir), 0);
        chk("wrap_no_err", int'(err_count), 0);

        // Direction change while locked
        do_reset();
        step(1, 19, 0);
        step(1, 20, 0);
        step(1, 19, 0);
        chk("dir_chg_pulse", int'(dir_chg), 1);
        chk("dir_chg_dir", int'(dir), 0);
        chk("dir_chg_no_err", int'(err_pulse), 0);
        step(1, 18, 0);
        chk("down_step_ok", int'(step_ok), 1);

        // Three misses lose lock; next good step relocks
        do_reset();
        step(1, 49, 0);
        step(1, 50, 0);
        step(1, 90, 0);
        step(1, 7, 0);
        chk("still_locked_2miss", int'(locked), 1);
        step(1, 7, 0);
        chk("lost_pulse", int'(lost), 1);
        chk("lost_unlocked", int'(locked), 0);
        chk("miss_err_count", int'(err_count), 3);
        step(1, 8, 0);
        chk("relock", int'(locked), 1);
        chk("relock_dir", int'(dir), 1);

        // Disabled samples change nothing
        for (int i = 0; i < 5; i++) step(0, int'($urandom_range(255)), 0);
        step(1, 9, 0);
        chk("hold_step_ok", int'(step_ok), 1);
        chk("hold_err_count", int'(err_count), 3);

`ifdef BDMON_IRQ_EN
        chk("irq_set", int'(irq), 1);
`else
        chk("irq_off", int'(irq), 0);
`endif

        // Clear beats a same-cycle error
        step(1, 50, 1);
        chk("clr_err_pulse", int'(err_pulse), 1);
        chk("clr_err_count", int'(err_count), 0);
        chk("clr_irq", int'(irq), 0);

        // Five errors interleaved with good steps: narrow tally saturates at 3
        step(1, 51, 0);
        step(1, 100, 0); step(1, 101, 0);
        step(1, 200, 0); step(1, 201, 0);
        step(1, 30, 0);  step(1, 31, 0);
        step(1, 60, 0);  step(1, 61, 0);
        step(1, 90, 0);
        chk("five_err_count", int'(err_count), 5);
        chk("sat_err_count", int'(s_err_count), 3);
        step(1, 91, 0);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bidi_count_monitor.md
Name: bidi_count_monitor

Overview:
- Receive-side checker for the 8-bit bidirectional pad counter stream: samples the count word arriving on user IO, infers the count direction, and locks onto the sequence.
- Flags step errors, direction changes and wrap-arounds; keeps saturating error and wrap tallies for the management SoC or LA probes.
- Sits in user_proj_example between io_in and the LA/IRQ outputs; uses the wishbone clock domain only.

Parameters:
- WIDTH, 8, width of the observed count word.
- CNT_W, 16, width of the err_count and wrap_count tally registers.
- MISS_LIMIT, 3, consecutive bad samples in LOCKED before lock is dropped (legal range 1..15).

Ports:
- clk  input  1  wb_clk_i; all state changes on its rising edge.
- reset  input  1  wb_rst_i; synchronous, active-high.
- sample_en  input  1  qualifies cnt_in this cycle.
- cnt_in  input  WIDTH  observed count word.
- clr  input  1  synchronous clear of tallies and sticky flags only; does not affect lock state.
- locked  output  1  high while the FSM is in LOCKED.
- dir  output  1  inferred direction; 1 = up, 0 = down.
- step_ok  output  1  one-cycle pulse: a sample matched the expected step.
- err_pulse  output  1  one-cycle pulse: a sample mismatched while LOCKED.
- dir_chg  output  1  one-cycle pulse: a valid step in the opposite direction was seen.
- wrap_pulse  output  1  one-cycle pulse: a valid 255->0 (up) or 0->255 (down) step was seen.
- lost  output  1  one-cycle pulse: lock was dropped after MISS_LIMIT misses.
- err_count  output  CNT_W  saturating count of err_pulse events.
- wrap_count  output  CNT_W  saturating count of wrap_pulse events.
- irq  output  1  sticky error interrupt; see Optional Feature.

Behaviour:
- Reset values: FSM = IDLE, prev = 0, dir = 1, all pulses = 0, both tallies = 0, miss = 0, irq = 0.
- reset has priority over clr, and clr has priority over tally increments in the same cycle.
- All outputs are registered. Pulses assert exactly one cycle after the clk edge that sampled the qualifying cnt_in. Cycles with sample_en = 0 change no state and produce no pulses.
- Step arithmetic is modulo 2^WIDTH:
  - up = prev + 1
  - down = prev - 1
- FSM states and transitions:
  - IDLE: first enabled sample loads prev and moves to ACQ. No pulses.
  - ACQ:
    - cnt_in == up -> dir = 1, go to LOCKED, step_ok.
    - cnt_in == down -> dir = 0, go to LOCKED, step_ok.
    - Any other value -> stay in ACQ. No error is counted.
    - prev is always reloaded with cnt_in.
  - LOCKED:
    - Value is the expected step in the current dir -> step_ok, miss = 0.
    - Value is the step in the opposite direction -> flip dir, dir_chg and step_ok, miss = 0.
    - Any other value, including cnt_in == prev -> err_pulse, err_count + 1, miss + 1. If miss reaches MISS_LIMIT -> lost, go to ACQ, miss = 0.
    - prev is always reloaded with cnt_in.
- A wrap step also asserts wrap_pulse and increments wrap_count, in both ACQ->LOCKED and LOCKED.
- Tallies saturate at 2^CNT_W - 1 and never roll over.
- A mid-run jump to 0 (for example the source counter being reset) is an ordinary miss.
- Reset mid-operation returns to IDLE the next cycle regardless of state.

Optional Feature:
- Macro BDMON_IRQ_EN.
- Defined: irq sets on any err_pulse or lost, and stays high until clr or reset.
- Undefined: irq is tied 0, no irq logic is synthesised, and all other behaviour is identical.

Test Plan:
- Reset, then sample 10, 11, 12, 13 -> locked = 1 after the 11 sample, dir = 1, step_ok on 3 samples, err_count = 0.
- Lock up, then feed 254, 255, 0, 1 -> wrap_pulse once (on 0), wrap_count = 1, no err_pulse. Repeat down through 1, 0, 255 -> wrap_count = 2, dir = 0.
- Locked up at 20, then feed 19 -> dir_chg pulse, dir = 0, no error. Then feed 18 -> step_ok.
- Locked at 50 (up), MISS_LIMIT = 3, feed 90, 7, 7 -> three err_pulse, err_count = 3, lost on the third, locked = 0. Then feed 8 -> relocked, dir = 1.
- Drive sample_en = 0 for 5 cycles with random cnt_in -> no state change. Set clr with a simultaneous error -> err_count reads 0. With CNT_W = 2, five errors -> err_count = 3 (saturated).
- With BDMON_IRQ_EN defined, one bad sample sets irq = 1, it holds until clr, then reads 0. Without the macro, irq = 0 throughout.
